// File: rtl/param_scan_mux.sv
// Registered N-to-1 channel selector with valid/ready output and optional auto-scan.
// Define PSM_SCAN_EN to build the SCAN state, tick counter and mode input.
module param_scan_mux #(
    parameter int unsigned CH    = 26,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = 5,
    parameter int unsigned DIV   = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CH*W-1:0]   x_flat,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sel_load,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  y_idx,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              sel_err,
    output logic              overrun
);

    // One extra bit so CH == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] ChExt = (SEL_W + 1)'(CH);

    logic [W-1:0]     y_q;
    logic [SEL_W-1:0] y_idx_q;
    logic             y_valid_q, y_valid_d;
    logic             sel_err_q, sel_err_d;
    logic             overrun_q, overrun_d;

    logic             ev;
    logic [SEL_W-1:0] ev_idx;
    logic [W-1:0]     ev_data;
    logic             busy;
    logic             sel_ok;

    assign busy   = y_valid_q && !y_ready;
    assign sel_ok = {1'b0, sel} < ChExt;

`ifdef PSM_SCAN_EN
    localparam int unsigned      CntW    = $clog2(DIV);
    localparam logic [CntW-1:0]  CntLast = CntW'(DIV - 1);
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(CH - 1);

    typedef enum logic [0:0] {StMan, StScan} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0] next_idx;

    assign next_idx = (y_idx_q == LastIdx) ? '0 : y_idx_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StMan;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ev        = 1'b0;
        ev_idx    = '0;
        sel_err_d = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            StMan: begin
                if (mode) begin
                    // Entry edge captures channel 0 and restarts the tick period.
                    state_d   = StScan;
                    cnt_d     = '0;
                    ev        = 1'b1;
                    ev_idx    = '0;
                    overrun_d = busy;
                end else if (sel_load) begin
                    ev        = 1'b1;
                    ev_idx    = sel_ok ? sel : '0;
                    sel_err_d = !sel_ok;
                    overrun_d = busy;
                end
            end
            StScan: begin
                if (!mode) begin
                    state_d = StMan;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    // Pending tick stalls here until the output slot is free.
                    if (!busy) begin
                        ev     = 1'b1;
                        ev_idx = next_idx;
                        cnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StMan;
        endcase
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        ev        = 1'b0;
        ev_idx    = '0;
        sel_err_d = 1'b0;
        overrun_d = 1'b0;
        if (sel_load) begin
            ev        = 1'b1;
            ev_idx    = sel_ok ? sel : '0;
            sel_err_d = !sel_ok;
            overrun_d = busy;
        end
    end
`endif

    always_comb begin
        ev_data = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (ev_idx == SEL_W'(k)) begin
                ev_data = x_flat[k*W +: W];
            end
        end
    end

    always_comb begin
        y_valid_d = y_valid_q;
        if (ev) begin
            y_valid_d = 1'b1;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q       <= '0;
            y_idx_q   <= '0;
            y_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (ev) begin
                y_q     <= ev_data;
                y_idx_q <= ev_idx;
            end
            y_valid_q <= y_valid_d;
            sel_err_q <= sel_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign y       = y_q;
    assign y_idx   = y_idx_q;
    assign y_valid = y_valid_q;
    assign sel_err = sel_err_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_param_scan_mux.sv
// Directed, table-driven bench for param_scan_mux; scan checks need PSM_SCAN_EN.
module tb_param_scan_mux;

    localparam int unsigned CH    = 26;
    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned DIV   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [CH*W-1:0]   x_flat;
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic              sel_load;
    logic [W-1:0]      y;
    logic [SEL_W-1:0]  y_idx;
    logic              y_valid;
    logic              y_ready;
    logic              sel_err;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    param_scan_mux #(.CH(CH), .W(W), .SEL_W(SEL_W), .DIV(DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .x_flat   (x_flat),
        .mode     (mode),
        .sel      (sel),
        .sel_load (sel_load),
        .y        (y),
        .y_idx    (y_idx),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .sel_err  (sel_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             ld;
        logic [SEL_W-1:0] s;
        logic             rdy;
        logic [W-1:0]     ey;
        logic [SEL_W-1:0] ei;
        logic             ev;
        logic             ee;
        logic             eo;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [W-1:0] xval(input int k);
        return (k == 0) ? 8'h41 : 8'(8'h40 + k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_idx"}, 32'(y_idx), 0);
        check({tag, "_valid"}, 32'(y_valid), 0);
        check({tag, "_err"}, 32'(sel_err), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    // Asserts reset mid-cycle, checks outputs clear before any edge, then releases.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_all_zero(tag);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        mode     = 1'b0;
        sel      = '0;
        sel_load = 1'b0;
        y_ready  = 1'b1;
        for (int k = 0; k < CH; k++) x_flat[k*W +: W] = xval(k);

        //        ld   sel    rdy   y      idx    v     err   ovr
        vecs[0]  = '{1'b1, 5'd3,  1'b1, 8'h43, 5'd3,  1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  1'b1, 8'h43, 5'd3,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd27, 1'b1, 8'h41, 5'd0,  1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  1'b1, 8'h41, 5'd0,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd26, 1'b0, 8'h41, 5'd0,  1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd25, 1'b0, 8'h59, 5'd25, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  1'b0, 8'h59, 5'd25, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd5,  1'b1, 8'h45, 5'd5,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  1'b1, 8'h45, 5'd5,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd5,  1'b0, 8'h45, 5'd5,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd6,  1'b0, 8'h46, 5'd6,  1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  1'b0, 8'h46, 5'd6,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  1'b1, 8'h46, 5'd6,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 5'd31, 1'b1, 8'h41, 5'd0,  1'b1, 1'b1, 1'b0};

        #3 check_all_zero("init_rst");
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            sel_load = vecs[i].ld;
            sel      = vecs[i].s;
            y_ready  = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].ey));
            check($sformatf("vec%0d_idx", i), 32'(y_idx), 32'(vecs[i].ei));
            check($sformatf("vec%0d_valid", i), 32'(y_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_err", i), 32'(sel_err), 32'(vecs[i].ee));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].eo));
        end
        sel_load = 1'b0;

`ifdef PSM_SCAN_EN
        // Scan wrap: samples every DIV cycles, index 0..25 then back to 0.
        async_reset("rst_pre_scan");
        y_ready = 1'b1;
        mode    = 1'b1;
        for (int c = 0; c <= 26 * DIV; c++) begin
            tick();
            check($sformatf("scan_c%0d_valid", c), 32'(y_valid), 32'(c % DIV == 0));
            check($sformatf("scan_c%0d_idx", c), 32'(y_idx), 32'((c / DIV) % CH));
            if (c % DIV == 0) begin
                check($sformatf("scan_c%0d_y", c), 32'(y), 32'(xval((c / DIV) % CH)));
            end
        end

        // Backpressure: tick stalls at DIV-1, then fires on the first free edge.
        async_reset("rst_pre_bp");
        mode = 1'b1;
        tick();
        repeat (DIV) tick();
        check("bp_idx1", 32'(y_idx), 1);
        y_ready = 1'b0;
        repeat (DIV + 2) tick();
        check("bp_stall_idx", 32'(y_idx), 1);
        check("bp_stall_valid", 32'(y_valid), 1);
        check("bp_stall_ovr", 32'(overrun), 0);
        check("bp_stall_cnt", 32'(dut.cnt_q), DIV - 1);
        y_ready = 1'b1;
        tick();
        check("bp_rel_idx", 32'(y_idx), 2);
        check("bp_rel_y", 32'(y), 32'(8'h42));
        check("bp_rel_valid", 32'(y_valid), 1);
        check("bp_rel_ovr", 32'(overrun), 0);
        repeat (DIV - 1) tick();
        check("bp_gap_valid", 32'(y_valid), 0);
        tick();
        check("bp_next_idx", 32'(y_idx), 3);
        check("bp_next_valid", 32'(y_valid), 1);

        // Reset while scanning with a held sample.
        async_reset("rst_scan");
        check("rst_scan_state", 32'(dut.state_q), 0);
        check("rst_scan_cnt", 32'(dut.cnt_q), 0);
        mode = 1'b0;
        tick();
        check("rst_scan_stays_idle", 32'(y_valid), 0);

        // Leaving SCAN holds y and y_valid.
        mode = 1'b1;
        tick();
        y_ready = 1'b0;
        mode    = 1'b0;
        tick();
        check("exit_valid", 32'(y_valid), 1);
        check("exit_idx", 32'(y_idx), 0);
        check("exit_y", 32'(y), 32'(8'h41));
        check("exit_state", 32'(dut.state_q), 0);
        sel_load = 1'b1;
        sel      = 5'd2;
        y_ready  = 1'b1;
        tick();
        sel_load = 1'b0;
        check("exit_then_load_idx", 32'(y_idx), 2);
`else
        // Without scan support mode must do nothing.
        mode    = 1'b1;
        y_ready = 1'b1;
        tick();
        tick();
        check("noscan_valid", 32'(y_valid), 0);
        check("noscan_idx", 32'(y_idx), 0);
        sel_load = 1'b1;
        sel      = 5'd7;
        y_ready  = 1'b0;
        tick();
        sel_load = 1'b0;
        check("noscan_load_idx", 32'(y_idx), 7);
        check("noscan_load_y", 32'(y), 32'(8'h47));
        async_reset("rst_valid");
        mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
